sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO. It generalises our 32×24 dual-clock FIFO to any power-of-two depth and any data width. It adds almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between producer and consumer stages that share one clock domain. It exposes the same pointer and used-words observability as the existing FIFO, so existing bench checks carry over.

## Interface
- WIDTH, 24, data word width in bits (≥1)
- DEPTH, 32, number of storage words; power of two, ≥4
- AF_LEVEL, DEPTH-4, almost_full asserts when used_words ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 4, almost_empty asserts when used_words ≤ AE_LEVEL (0..DEPTH-1)
- Derived: AW = $clog2(DEPTH); pointers and used_words are AW+1 bits wide

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- async_reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of contents and error flags
- write_enable  in  1  write request
- data_in  in  WIDTH  write data
- read_enable  in  1  read request
- data_out  out  WIDTH  read data
- FULL  out  1  used_words == DEPTH
- EMPTY  out  1  used_words == 0
- almost_full  out  1  threshold flag, as defined by AF_LEVEL
- almost_empty  out  1  threshold flag, as defined by AE_LEVEL
- overflow  out  1  sticky: a write was attempted while FULL
- underflow  out  1  sticky: a read was attempted while EMPTY
- read_pointer  out  AW+1  read pointer including wrap bit
- write_pointer  out  AW+1  write pointer including wrap bit
- used_words  out  AW+1  occupancy, 0..DEPTH

## Operation
- **Reset values.** Reset asserted (async_reset_n=0, immediately, no clock needed) sets:
  - read_pointer = write_pointer = used_words = 0
  - EMPTY = 1, FULL = 0
  - almost_empty = 1, almost_full = (AF_LEVEL == 0 ? 1 : 0), which is 0 for legal AF_LEVEL
  - overflow = underflow = 0, data_out = 0
  - Memory contents are not reset.
- **Accepted write.** wr_ok = write_enable && !FULL. The word is stored at mem[write_pointer[AW-1:0]] and write_pointer increments by 1 modulo 2^(AW+1).
- **Accepted read.** rd_ok = read_enable && !EMPTY. read_pointer increments by 1 modulo 2^(AW+1).
- **Flag basis.** FULL and EMPTY are the registered values from before the edge. A write while FULL is dropped even if a read is accepted in the same cycle. A read while EMPTY is dropped even if a write is accepted in the same cycle.
- **Occupancy.** used_words = write_pointer − read_pointer, computed mod 2^(AW+1). The same result follows from the per-cycle update:
  - +1 on write only
  - −1 on read only
  - unchanged when both are accepted
  - unchanged when neither is accepted
- **FULL / EMPTY decode.** FULL when the pointers differ only in the MSB. EMPTY when the pointers are equal.
- **Error flags.**
  - overflow is set when write_enable && FULL.
  - underflow is set when read_enable && EMPTY.
  - Both hold until flush or reset.
- **Flush.** flush=1 takes priority over all reads and writes in that cycle. The next state equals the reset state, except data_out, which holds its value.
- **Flag registers.** All flags are registered and consistent with used_words after every edge. FULL and EMPTY are never both 1.

## Timing
- Write-to-EMPTY deassert: 1 cycle. Read-to-FULL deassert: 1 cycle.
- **Standard mode.**
  - data_out is registered and loads mem[read_pointer] on the edge that accepts the read.
  - Read latency is 1 cycle.
  - data_out holds its value when no read is accepted.
- **Wrap-around.** Pointers pass from 2·DEPTH−1 to 0. At DEPTH=32 this is 0x3F → 0x00.
- **Reset mid-operation.** Any in-flight read or write is discarded and outputs take reset values asynchronously. Deassertion is synchronised externally.

## Configuration
- **Macro:** SYNC_FIFO_FWFT_EN.
- **Defined (first-word-fall-through).**
  - data_out = mem[read_pointer[AW-1:0]], read combinationally from the array.
  - The head word is visible whenever EMPTY=0. read_enable acknowledges it and advances to the next word.
  - data_out is undefined while EMPTY=1.
- **Undefined.** Standard registered mode, as described under Timing.
- All flags and pointers behave identically in both builds.

## Structure
- **Package fifo_pkg** holds:
  - default WIDTH and DEPTH constants
  - a ptr_t typedef helper built from a localparam AW
  - a function that checks DEPTH is a power of two
  - the error-flag struct {overflow, underflow}
- **Sub-module fifo_ram:** DEPTH×WIDTH array with one synchronous write port and one read port. The read port is registered or combinational, selected by the FWFT macro.
- **Top module** holds the pointers, flags, occupancy and flush logic.

## Test plan
- **Reset.** Assert async_reset_n=0 mid-write with clock stopped → EMPTY=1, FULL=0, pointers=0, used_words=0, data_out=0 with no clock edge.
- **Fill.** Write 32 words with 0x000000–0x00001F → used_words=32, FULL=1, write_pointer=0x20. almost_full asserts at used_words=28. A 33rd write sets overflow=1 and leaves write_pointer=0x20.
- **Drain.** Read 32 words → data_out sequence 0x000000..0x00001F (standard mode: 1 cycle after each read), EMPTY=1, read_pointer=0x20. A further read sets underflow=1 and leaves read_pointer unchanged.
- **Simultaneous operations.**
  - With used_words=10, read+write → used_words stays 10 and both pointers +1.
  - When EMPTY, read+write → write only, used_words=1.
  - When FULL, read+write → read only, used_words=31.
- **Wrap.** Write and read 80 words continuously → pointers pass 0x3F→0x00, FIFO order is preserved, and used_words is never >32.
- **Flush.** Flush with used_words=17 and overflow=1 → next cycle used_words=0, EMPTY=1, overflow=0. In the FWFT build, the first write after flush appears on data_out in the same cycle that EMPTY falls.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared defaults, pointer type, depth check and error-flag
//               struct for the parametrised single-clock FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 24;
    localparam int DEFAULT_DEPTH = 32;
    localparam int AW            = $clog2(DEFAULT_DEPTH);

    // Pointer carries one extra wrap bit above the address bits.
    typedef logic [AW:0] ptr_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : DEPTH x WIDTH storage, one synchronous write port and one read
//               port; registered read by default, combinational read when
//               SYNC_FIFO_FWFT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram #(
    parameter  int WIDTH = 24,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             async_reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage is deliberately left without reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data = r_mem[rd_addr];

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, rd_en, async_reset_n};
`else
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clock or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;
`endif

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Single-clock FIFO with power-of-two depth, threshold flags,
//               sticky overflow/underflow and synchronous flush.
//               Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                       clock,
    input  logic                       async_reset_n,
    input  logic                       flush,
    input  logic                       write_enable,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       read_enable,
    output logic [WIDTH-1:0]           data_out,
    output logic                       FULL,
    output logic                       EMPTY,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow,
    output logic [$clog2(DEPTH):0]     read_pointer,
    output logic [$clog2(DEPTH):0]     write_pointer,
    output logic [$clog2(DEPTH):0]     used_words
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [AW:0] c_af_level  = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] c_ae_level  = (AW+1)'(AE_LEVEL);
    localparam logic        c_af_reset  = (AF_LEVEL == 0);
    localparam logic [AW:0] c_full_diff = {1'b1, {AW{1'b0}}};

    if (!is_pow2(DEPTH) || (DEPTH < 4)) begin : g_depth_check
        $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
    end

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] r_used;
    logic        r_full;
    logic        r_empty;
    logic        r_af;
    logic        r_ae;
    err_flags_t  r_err;

    logic        w_wr_ok;
    logic        w_rd_ok;
    logic [AW:0] w_wr_ptr_nxt;
    logic [AW:0] w_rd_ptr_nxt;
    logic [AW:0] w_used_nxt;
    err_flags_t  w_err_nxt;

    // Acceptance uses the registered flags, so a simultaneous opposite
    // operation never rescues a write-while-full or read-while-empty.
    always_comb begin
        w_wr_ok      = write_enable && !r_full;
        w_rd_ok      = read_enable && !r_empty;
        w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_wr_ok);
        w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(w_rd_ok);
        w_used_nxt   = w_wr_ptr_nxt - w_rd_ptr_nxt;
        w_err_nxt    = r_err;
        if (write_enable && r_full) begin
            w_err_nxt.overflow = 1'b1;
        end
        if (read_enable && r_empty) begin
            w_err_nxt.underflow = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_used   <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= c_af_reset;
            r_ae     <= 1'b1;
            r_err    <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_used   <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= c_af_reset;
            r_ae     <= 1'b1;
            r_err    <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_used   <= w_used_nxt;
            r_full   <= (w_wr_ptr_nxt ^ w_rd_ptr_nxt) == c_full_diff;
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_af     <= (w_used_nxt >= c_af_level);
            r_ae     <= (w_used_nxt <= c_ae_level);
            r_err    <= w_err_nxt;
        end
    end

    // Flush blocks the array so the read register holds its last word.
    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock         (clock),
        .async_reset_n (async_reset_n),
        .wr_en         (w_wr_ok && !flush),
        .wr_addr       (r_wr_ptr[AW-1:0]),
        .wr_data       (data_in),
        .rd_en         (w_rd_ok && !flush),
        .rd_addr       (r_rd_ptr[AW-1:0]),
        .rd_data       (data_out)
    );

    assign FULL          = r_full;
    assign EMPTY         = r_empty;
    assign almost_full   = r_af;
    assign almost_empty  = r_ae;
    assign overflow      = r_err.overflow;
    assign underflow     = r_err.underflow;
    assign read_pointer  = r_rd_ptr;
    assign write_pointer = r_wr_ptr;
    assign used_words    = r_used;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench for sync_fifo_param against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int WIDTH = 24;
    localparam int DEPTH = 32;
    localparam int AF    = 28;
    localparam int AE    = 4;
    localparam int AW    = 5;

    logic             clock         = 1'b0;
    logic             clk_run       = 1'b1;
    logic             async_reset_n = 1'b1;
    logic             flush         = 1'b0;
    logic             write_enable  = 1'b0;
    logic             read_enable   = 1'b0;
    logic [WIDTH-1:0] data_in       = '0;
    logic [WIDTH-1:0] data_out;
    logic             FULL, EMPTY, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]      read_pointer, write_pointer, used_words;

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue, pointers as op counts mod 2*DEPTH.
    logic [WIDTH-1:0] q[$];
    int               m_wp, m_rp;
    bit               m_ovf, m_udf;
    logic [WIDTH-1:0] m_dout;

    sync_fifo_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clock         (clock),
        .async_reset_n (async_reset_n),
        .flush         (flush),
        .write_enable  (write_enable),
        .data_in       (data_in),
        .read_enable   (read_enable),
        .data_out      (data_out),
        .FULL          (FULL),
        .EMPTY         (EMPTY),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .overflow      (overflow),
        .underflow     (underflow),
        .read_pointer  (read_pointer),
        .write_pointer (write_pointer),
        .used_words    (used_words)
    );

    always #5 if (clk_run) clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wp   = 0;
        m_rp   = 0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = '0;
    endtask

    task automatic model_step(input bit we, input bit re, input bit fl, input logic [WIDTH-1:0] d);
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (fl) begin
            q.delete();
            m_wp  = 0;
            m_rp  = 0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (we && was_full)  m_ovf = 1'b1;
            if (re && was_empty) m_udf = 1'b1;
            if (re && !was_empty) begin
                m_dout = q.pop_front();
                m_rp   = (m_rp + 1) % (2 * DEPTH);
            end
            if (we && !was_full) begin
                q.push_back(d);
                m_wp = (m_wp + 1) % (2 * DEPTH);
            end
        end
    endtask

    task automatic check_state(input string ph);
        chk({ph, ":used"},  32'(used_words),    32'(q.size()));
        chk({ph, ":full"},  32'(FULL),          32'(q.size() == DEPTH));
        chk({ph, ":empty"}, 32'(EMPTY),         32'(q.size() == 0));
        chk({ph, ":af"},    32'(almost_full),   32'(q.size() >= AF));
        chk({ph, ":ae"},    32'(almost_empty),  32'(q.size() <= AE));
        chk({ph, ":ovf"},   32'(overflow),      32'(m_ovf));
        chk({ph, ":udf"},   32'(underflow),     32'(m_udf));
        chk({ph, ":wptr"},  32'(write_pointer), 32'(m_wp));
        chk({ph, ":rptr"},  32'(read_pointer),  32'(m_rp));
`ifdef SYNC_FIFO_FWFT_EN
        if (q.size() != 0) chk({ph, ":head"}, 32'(data_out), 32'(q[0]));
`else
        chk({ph, ":dout"}, 32'(data_out), 32'(m_dout));
`endif
    endtask

    task automatic cycle(input bit we, input bit re, input bit fl, input logic [WIDTH-1:0] d,
                         input string ph);
        write_enable = we;
        read_enable  = re;
        flush        = fl;
        data_in      = d;
        @(posedge clock);
        model_step(we, re, fl, d);
        #1;
        check_state(ph);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Reset applied before the first clock edge.
        #1 async_reset_n = 1'b0;
        #1 check_state("reset0");
        @(posedge clock);
        @(negedge clock);
        async_reset_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, WIDTH'(i), "fill");
        cycle(1'b1, 1'b0, 1'b0, WIDTH'(24'h33), "ovf_write");

        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, WIDTH'($urandom), "drain");
        cycle(1'b0, 1'b1, 1'b0, '0, "udf_read");

        cycle(1'b0, 1'b0, 1'b1, '0, "flush0");
        cycle(1'b1, 1'b1, 1'b0, WIDTH'(24'h0ABCDE), "rw_empty");
        while (q.size() < 10) cycle(1'b1, 1'b0, 1'b0, WIDTH'($urandom), "to10");
        cycle(1'b1, 1'b1, 1'b0, WIDTH'($urandom), "rw_10");
        while (q.size() < DEPTH) cycle(1'b1, 1'b0, 1'b0, WIDTH'($urandom), "to_full");
        cycle(1'b1, 1'b1, 1'b0, WIDTH'($urandom), "rw_full");

        while (q.size() > 17) cycle(1'b0, 1'b1, 1'b0, '0, "to17");
        cycle(1'b0, 1'b0, 1'b1, '0, "flush17");
        cycle(1'b1, 1'b0, 1'b0, WIDTH'(24'h5A5A5A), "post_flush_wr");
        cycle(1'b0, 1'b1, 1'b0, '0, "post_flush_rd");

        // Reset in the middle of a write with the clock held low.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, WIDTH'($urandom), "pre_mid");
        @(negedge clock);
        clk_run      = 1'b0;
        write_enable = 1'b1;
        data_in      = WIDTH'(24'h777777);
        #2 async_reset_n = 1'b0;
        model_reset();
        #1 check_state("reset_mid");
        write_enable = 1'b0;
        #3 async_reset_n = 1'b1;
        #2 clk_run = 1'b1;

        // Continuous streaming through the pointer wrap.
        for (int i = 0; i < 84; i++)
            cycle(i < 80, i >= 4, 1'b0, WIDTH'($urandom), "wrap");

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 99) < ((i < 200) ? 70 : 35),
                  $urandom_range(0, 99) < ((i < 200) ? 35 : 70),
                  $urandom_range(0, 99) == 0,
                  WIDTH'($urandom), "random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
